arcade_input_conditioner: RTL and testbench
===========================================

# arcade_input_conditioner

Registered input-conditioning stage between the arcade keyboard/joystick decoder and the game core. Takes raw active-high control bits on `clk_sys`. Produces clean active-low signals that the core samples directly:
- debounced, with opposing directions resolved;
- coin pulses of fixed width with a rate limit.

## Interface
Parameters:
- `TICK_DIV`, 24192, `clk_sys` cycles per debounce tick (1 kHz at 24.192 MHz); ≥2
- `DEB_TICKS`, 5, consecutive ticks an input must differ from its stable value before it changes; 1–15
- `COIN_HOLD_TICKS`, 100, ticks a coin output stays asserted; 1–255
- `COIN_GAP_TICKS`, 150, ticks after a coin pulse during which that coin input is ignored; 1–255

Ports:
- `clk_sys`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `coin_i`  in  2  raw coin switches [1]=coin2, [0]=coin1, active-high
- `start_i`  in  2  raw start buttons [1]=two players, [0]=one player, active-high
- `p1_dir_i`  in  4  player 1 {up,down,left,right}, active-high
- `p2_dir_i`  in  4  player 2 {up,down,left,right}, active-high
- `coin_n_o`  out  2  shaped coin pulses, active-low
- `start_n_o`  out  2  debounced starts, active-low
- `p1_dir_n_o`  out  4  debounced/resolved player 1 directions, active-low
- `p2_dir_n_o`  out  4  debounced/resolved player 2 directions, active-low

## Operation
- **Synchroniser:** every raw input passes a 2-FF synchroniser.
- **Tick prescaler:** counter 0..`TICK_DIV`-1. It wraps to 0 and emits a one-cycle `tick` when it reaches `TICK_DIV`-1.
- **Debounce cell** (one per input, 12 total): holds a `stable` bit and a 4-bit count.
  - On `tick` with synced ≠ stable, the count increments.
  - When the count reaches `DEB_TICKS`, `stable` takes the synced value and the count clears.
  - When synced = stable (any cycle), the count clears immediately.
  - A glitch shorter than `DEB_TICKS` ticks never reaches `stable`.
- **Direction resolution** (per player, on stable values):
  - up and down both stable-high → both outputs inactive;
  - left and right both stable-high → both outputs inactive;
  - otherwise pass through.
- **Coin FSM** (one per coin, 8-bit tick counter):
  - `IDLE`: stable rising edge → `PULSE`, counter = 0, output asserted.
  - `PULSE`: counts ticks. When counter = `COIN_HOLD_TICKS`-1 on a tick → `GAP`, counter = 0, output released.
  - `GAP`: counts ticks. When counter = `COIN_GAP_TICKS`-1 on a tick → `ARM`.
  - `ARM`: stable low → `IDLE`. Stable high (coin held) → stay. A held coin therefore yields exactly one pulse.
  - Edges during `PULSE`/`GAP` are ignored, not queued.
- **Starts:** debounced level only, no shaping.
- **Outputs:** all are registered and inverted from internal active-high values.

## Timing
- **Reset values:** all outputs 1 (inactive). Prescaler, counts and coin counters are 0, `stable` bits are 0, coin FSMs are in `IDLE`. Reset asserted mid-pulse releases `coin_n_o` immediately (asynchronous).
- **Input-to-output latency:**
  - 2 cycles for synchronisation;
  - `DEB_TICKS` ticks, where the first tick falls 1..`TICK_DIV` cycles after the synced change;
  - 1 cycle for the output register.
- **Coin pulse:**
  - `coin_n_o` falls 1 cycle after the `stable` rising edge.
  - It stays low from `PULSE` entry until the `COIN_HOLD_TICKS`-th following tick, i.e. (`COIN_HOLD_TICKS`-1)·`TICK_DIV`+1 .. `COIN_HOLD_TICKS`·`TICK_DIV` cycles.
- **Opposing-direction change:** applies in the same cycle that `stable` updates, so there is no one-cycle both-active output.
- **Simultaneous coins:** both FSMs are independent and both may pulse together.
- **Prescaler wrap:** exactly one `tick` per `TICK_DIV` cycles, with no drift across the wrap.

## Structure
- Package `arcade_input_pkg`:
  - coin FSM state enum `{IDLE, PULSE, GAP, ARM}`;
  - direction bit indices UP=3, DOWN=2, LEFT=1, RIGHT=0;
  - widths (debounce count 4, coin count 8).
- Sub-module `input_debounce`: one synchroniser plus one debounce cell, with ports `clk_sys`, `reset`, `tick`, `d_i`, `q_o`. It is instantiated 12 times.
- Top level holds the prescaler, direction resolution, the two coin FSMs and the output registers.

## Test plan
Bench parameters: `TICK_DIV`=4, `DEB_TICKS`=3, `COIN_HOLD_TICKS`=5, `COIN_GAP_TICKS`=4.
- **Reset:** assert `reset` with all inputs high → all outputs 1 while reset is held. Deassert → outputs 1 until debounce completes.
- **Glitch rejection and latency:**
  - `start_i[0]` high for 8 cycles (2 ticks), then low → `start_n_o[0]` never falls.
  - Held high → `start_n_o[0]` falls within 2+12+1 = 15 cycles.
- **Coin pulse:** `coin_i[0]` held high 200 cycles → exactly one `coin_n_o[0]` low pulse of 17–20 cycles. A second pulse appears only after release plus a new press.
- **Rate limit:** second `coin_i[0]` press during `GAP` → no pulse. Press after `ARM`→`IDLE` → pulse.
- **Opposing directions:**
  - `p1_dir_i`=4'b1100 stable → `p1_dir_n_o`=4'b1111.
  - `p1_dir_i`=4'b1010 → `p1_dir_n_o`=4'b0101.
- **Reset mid-pulse:** assert `reset` during `PULSE` → `coin_n_o` goes 1 in the same cycle. After release the FSM is in `IDLE` and a new press yields a full pulse.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared types, widths and helpers for the arcade input conditioner.
package arcade_input_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, ARM} coin_state_t;

    localparam int UP    = 3;
    localparam int DOWN  = 2;
    localparam int LEFT  = 1;
    localparam int RIGHT = 0;

    localparam int DEB_CNT_W  = 4;
    localparam int COIN_CNT_W = 8;

    // Opposing directions held together cancel each other out.
    function automatic logic [3:0] resolve_dirs(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[UP] && d[DOWN]) begin
            r[UP]   = 1'b0;
            r[DOWN] = 1'b0;
        end
        if (d[LEFT] && d[RIGHT]) begin
            r[LEFT]  = 1'b0;
            r[RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One raw control bit: 2-FF synchroniser followed by a tick-based debounce cell.
module input_debounce
    import arcade_input_pkg::*;
#(
    parameter int DEB_TICKS = 5
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic tick,
    input  logic d_i,
    output logic q_o
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_TICKS - 1);

    logic [1:0]           sync_ff;
    logic                 stable;
    logic [DEB_CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
            stable  <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], d_i};
            // Any cycle of agreement restarts the qualification window.
            if (sync_ff[1] == stable) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == DEB_LAST) begin
                    stable <= sync_ff[1];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign q_o = stable;

endmodule

// File: rtl/arcade_input_conditioner.sv
// Debounces arcade controls, resolves opposing directions and shapes coin pulses.
module arcade_input_conditioner
    import arcade_input_pkg::*;
#(
    parameter int TICK_DIV        = 24192,
    parameter int DEB_TICKS       = 5,
    parameter int COIN_HOLD_TICKS = 100,
    parameter int COIN_GAP_TICKS  = 150
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] coin_i,
    input  logic [1:0] start_i,
    input  logic [3:0] p1_dir_i,
    input  logic [3:0] p2_dir_i,
    output logic [1:0] coin_n_o,
    output logic [1:0] start_n_o,
    output logic [3:0] p1_dir_n_o,
    output logic [3:0] p2_dir_n_o
);

    localparam int NUM_IN = 12;
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [COIN_CNT_W-1:0] HOLD_LAST = COIN_CNT_W'(COIN_HOLD_TICKS - 1);
    localparam logic [COIN_CNT_W-1:0] GAP_LAST  = COIN_CNT_W'(COIN_GAP_TICKS - 1);

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] stable;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;

    assign raw  = {p2_dir_i, p1_dir_i, start_i, coin_i};
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        input_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk_sys (clk_sys),
            .reset   (reset),
            .tick    (tick),
            .d_i     (raw[i]),
            .q_o     (stable[i])
        );
    end

    // Independent coin shapers: one pulse per press, then a lockout window.
    for (genvar c = 0; c < 2; c++) begin : g_coin
        coin_state_t           state;
        logic [COIN_CNT_W-1:0] cnt;
        logic                  prev;
        logic                  pulse_n;

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                state   <= IDLE;
                cnt     <= '0;
                prev    <= 1'b0;
                pulse_n <= 1'b1;
            end else begin
                prev <= stable[c];
                case (state)
                    IDLE: if (stable[c] && !prev) begin
                        state   <= PULSE;
                        cnt     <= '0;
                        pulse_n <= 1'b0;
                    end
                    PULSE: if (tick) begin
                        if (cnt == HOLD_LAST) begin
                            state   <= GAP;
                            cnt     <= '0;
                            pulse_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: if (tick) begin
                        if (cnt == GAP_LAST) begin
                            state <= ARM;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ARM: if (!stable[c]) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end

        assign coin_n_o[c] = pulse_n;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            start_n_o  <= '1;
            p1_dir_n_o <= '1;
            p2_dir_n_o <= '1;
        end else begin
            start_n_o  <= ~stable[3:2];
            p1_dir_n_o <= ~resolve_dirs(stable[7:4]);
            p2_dir_n_o <= ~resolve_dirs(stable[11:8]);
        end
    end

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Randomised and directed bench; a tick-arithmetic reference model feeds a scoreboard queue.
module tb_arcade_input_conditioner;

    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int HOLD = 5;
    localparam int GAPT = 4;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] coin_i  = '0;
    logic [1:0] start_i = '0;
    logic [3:0] p1_dir_i = '0;
    logic [3:0] p2_dir_i = '0;
    logic [1:0] coin_n_o;
    logic [1:0] start_n_o;
    logic [3:0] p1_dir_n_o;
    logic [3:0] p2_dir_n_o;

    arcade_input_conditioner #(
        .TICK_DIV(TD), .DEB_TICKS(DEB), .COIN_HOLD_TICKS(HOLD), .COIN_GAP_TICKS(GAPT)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .coin_i     (coin_i),
        .start_i    (start_i),
        .p1_dir_i   (p1_dir_i),
        .p2_dir_i   (p2_dir_i),
        .coin_n_o   (coin_n_o),
        .start_n_o  (start_n_o),
        .p1_dir_n_o (p1_dir_n_o),
        .p2_dir_n_o (p2_dir_n_o)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Number of tick cycles (cycle % TD == TD-1) within cycles [a, b].
    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TD - a / TD;
    endfunction

    // Cycle index of the n-th tick at or after cycle a.
    function automatic int nth_tick(input int a, input int n);
        return (a / TD) * TD + TD - 1 + (n - 1) * TD;
    endfunction

    function automatic logic [3:0] resolve(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[3] && d[2]) r[3:2] = 2'b00;
        if (d[1] && d[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    // Reference model: cycle k counts clock cycles since reset release.
    int          k;
    logic [11:0] h1, h2, st, st_prev;
    int          since [12];
    int          mode  [2];   // 0 idle, 1 pulsing or locked out, 2 waiting for release
    int          k0 [2];
    int          pe [2];
    int          ge [2];

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            k = 0; h1 = '0; h2 = '0; st = '0; st_prev = '0;
            for (int i = 0; i < 12; i++) since[i] = -1;
            for (int c = 0; c < 2; c++) begin
                mode[c] = 0; k0[c] = 0; pe[c] = 0; ge[c] = 0;
            end
            exp_q.delete();
        end else begin : model_step
            logic [11:0] raw, syn, nst;
            logic [1:0]  cexp;
            raw = {p2_dir_i, p1_dir_i, start_i, coin_i};
            syn = h2;
            for (int c = 0; c < 2; c++) begin
                if (mode[c] == 1 && k == ge[c]) mode[c] = 2;
                else if (mode[c] == 2 && !st[c]) mode[c] = 0;
                else if (mode[c] == 0 && st[c] && !st_prev[c]) begin
                    mode[c] = 1;
                    k0[c]   = k;
                    pe[c]   = nth_tick(k + 1, HOLD);
                    ge[c]   = nth_tick(pe[c] + 1, GAPT);
                end
                cexp[c] = (mode[c] == 1 && k < pe[c]) ? 1'b0 : 1'b1;
            end
            exp_q.push_back({~resolve(st[11:8]), ~resolve(st[7:4]), ~st[3:2], cexp});
            nst = st;
            for (int i = 0; i < 12; i++) begin
                if (syn[i] == st[i]) since[i] = -1;
                else begin
                    if (since[i] < 0) since[i] = k;
                    if ((k % TD) == TD - 1 && ticks_in(since[i], k) == DEB) begin
                        nst[i]   = syn[i];
                        since[i] = -1;
                    end
                end
            end
            st_prev = st;
            st      = nst;
            h2      = h1;
            h1      = raw;
            k++;
        end
    end

    // Monitor: compare each registered output word, measure coin-1 pulses.
    int falls = 0;
    int run   = 0;
    bit start0_low = 1'b0;

    always @(negedge clk_sys) begin : monitor
        logic [11:0] act;
        logic [11:0] e;
        act = {p2_dir_n_o, p1_dir_n_o, start_n_o, coin_n_o};
        if (reset) begin
            chk("reset_outputs", act, 12'hFFF);
            run = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("model_outputs", act, e);
            end
            if (coin_n_o[0] == 1'b0) begin
                if (run == 0) falls++;
                run++;
            end else if (run > 0) begin
                n_tests++;
                if (run < (HOLD - 1) * TD + 1 || run > HOLD * TD) begin
                    n_fail++;
                    $display("FAIL coin_width: got %0d cycles, expected %0d..%0d",
                             run, (HOLD - 1) * TD + 1, HOLD * TD);
                end
                run = 0;
            end
            if (start_n_o[0] == 1'b0) start0_low = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_coin_fall(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            if (coin_n_o[0] == 1'b0) seen = 1'b1;
        end
        chk(name, {11'd0, seen}, 12'd1);
    endtask

    int  f0;
    bit  found;

    initial begin
        // Reset held with every input active.
        coin_i = '1; start_i = '1; p1_dir_i = '1; p2_dir_i = '1;
        step(5);
        reset = 1'b0;
        step(40);
        coin_i = '0; start_i = '0; p1_dir_i = '0; p2_dir_i = '0;
        step(60);

        // Two-tick glitch on start 1 must be swallowed.
        start0_low = 1'b0;
        start_i[0] = 1'b1;
        step(8);
        start_i[0] = 1'b0;
        step(25);
        chk("glitch_reject", {11'd0, start0_low}, 12'd0);

        // Held start reaches the output within the worst-case latency.
        start_i[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step(1);
            if (start_n_o[0] == 1'b0) found = 1'b1;
        end
        chk("start_latency", {11'd0, found}, 12'd1);
        start_i[0] = 1'b0;
        step(20);

        // Opposing directions.
        p1_dir_i = 4'b1100;
        step(25);
        chk("dir_up_down", {8'd0, p1_dir_n_o}, 12'b1111);
        p1_dir_i = 4'b1010;
        step(25);
        chk("dir_up_left", {8'd0, p1_dir_n_o}, 12'b0101);
        p1_dir_i = 4'b0000;
        step(20);

        // Held coin gives exactly one pulse.
        f0 = falls;
        coin_i[0] = 1'b1;
        step(200);
        chk("coin_held_one_pulse", 12'(falls - f0), 12'd1);
        coin_i[0] = 1'b0;
        step(40);

        // Re-press while locked out is ignored; a later press pulses.
        f0 = falls;
        coin_i[0] = 1'b1;
        wait_coin_fall("coin_first_press");
        coin_i[0] = 1'b0;
        step(15);
        coin_i[0] = 1'b1;
        step(40);
        coin_i[0] = 1'b0;
        chk("coin_rate_limit", 12'(falls - f0), 12'd1);
        step(30);
        coin_i[0] = 1'b1;
        step(40);
        coin_i[0] = 1'b0;
        chk("coin_after_arm", 12'(falls - f0), 12'd2);
        step(40);

        // Reset in the middle of a pulse releases the coin output at once.
        coin_i[0] = 1'b1;
        wait_coin_fall("coin_pre_reset");
        step(3);
        reset = 1'b1;
        #1;
        chk("reset_mid_pulse", {10'd0, coin_n_o}, 12'b11);
        coin_i[0] = 1'b0;
        step(3);
        reset = 1'b0;
        f0 = falls;
        step(20);
        coin_i[0] = 1'b1;
        step(40);
        coin_i[0] = 1'b0;
        chk("coin_after_reset", 12'(falls - f0), 12'd1);
        step(40);

        // Random toggling on all twelve inputs.
        for (int n = 0; n < 3000; n++) begin : rnd
            logic [11:0] r;
            step(1);
            r = {p2_dir_i, p1_dir_i, start_i, coin_i};
            for (int b = 0; b < 12; b++)
                if ($urandom_range(15) == 0) r[b] = ~r[b];
            {p2_dir_i, p1_dir_i, start_i, coin_i} = r;
        end
        coin_i = '0; start_i = '0; p1_dir_i = '0; p2_dir_i = '0;
        step(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
